tc_sram_generic: RTL and testbench



---
 rtl/tc_sram_generic_pkg.sv | 51 +++++
 rtl/tc_sram_generic.sv | 158 +++++++++++++++
 tb/tb_tc_sram_generic.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/tc_sram_generic_pkg.sv
// tc_sram_generic_pkg
//   Shared types and helper functions for the generic SRAM model.
//   - sim_init_e         : decoded memory-content-at-reset mode
//   - decode_sim_init    : maps the SimInit string to sim_init_e
//   - sim_init_legal     : 1 when the SimInit string is a known mode
//   - calc_addr_width    : address width for a given depth (minimum 1)
//   - calc_be_width      : number of byte-enable lanes, last lane may be partial
//   - scramble           : deterministic 32-bit hash used for the "random" fill
package tc_sram_generic_pkg;

  typedef enum logic [1:0] {
    INIT_NONE   = 2'd0,
    INIT_ZEROS  = 2'd1,
    INIT_ONES   = 2'd2,
    INIT_RANDOM = 2'd3
  } sim_init_e;

  function automatic sim_init_e decode_sim_init(input string s);
    if (s == "zeros")  return INIT_ZEROS;
    if (s == "ones")   return INIT_ONES;
    if (s == "random") return INIT_RANDOM;
    return INIT_NONE;
  endfunction

  function automatic bit sim_init_legal(input string s);
    return (s == "none") || (s == "zeros") || (s == "ones") || (s == "random");
  endfunction

  function automatic int unsigned calc_addr_width(input int unsigned num_words);
    return (num_words > 1) ? $clog2(num_words) : 1;
  endfunction

  // A zero ByteWidth is rejected at elaboration; returning 1 keeps the
  // port widths legal long enough for that check to report.
  function automatic int unsigned calc_be_width(input int unsigned data_width,
                                                input int unsigned byte_width);
    if (byte_width == 0) return 1;
    return (data_width + byte_width - 1) / byte_width;
  endfunction

  function automatic logic [31:0] scramble(input int unsigned word_idx,
                                           input int unsigned chunk_idx);
    logic [31:0] x;
    x = (word_idx * 32'h9E37_79B9) ^ ((chunk_idx + 1) * 32'h85EB_CA6B);
    x = x ^ (x >> 16);
    x = x * 32'h7FEB_352D;
    x = x ^ (x >> 15);
    return x;
  endfunction

endpackage

// File: rtl/tc_sram_generic.sv
// tc_sram_generic
//   Technology-independent multi-port SRAM with byte-enabled synchronous
//   writes and registered reads of configurable latency.
//
//   Ports (one entry per port p in [0, NumPorts)):
//     clk_i           rising-edge clock
//     rst_ni          asynchronous active-low reset
//     req_i[p]        access request
//     we_i[p]         1 = write, 0 = read
//     addr_i[p]       word address
//     wdata_i[p]      write data
//     be_i[p]         byte enables, one bit per ByteWidth-bit lane
//     rdata_o[p]      read data, valid Latency cycles after a read request
//
//   Interface contract: there is no handshake. Every request is accepted in
//   the cycle it is presented; a read issued in cycle N returns data in cycle
//   N+Latency, and rdata_o holds until the next read (with Latency 1 it also
//   follows rewrites of the addressed word, since the lookup is live).
module tc_sram_generic
  import tc_sram_generic_pkg::*;
#(
  parameter int unsigned NumWords    = 1024,
  parameter int unsigned DataWidth   = 128,
  parameter int unsigned ByteWidth   = 8,
  parameter int unsigned NumPorts    = 2,
  parameter int unsigned Latency     = 1,
  parameter string       SimInit     = "none",
  parameter bit          PrintSimCfg = 1'b0,
  localparam int unsigned AddrWidth  = calc_addr_width(NumWords),
  localparam int unsigned BeWidth    = calc_be_width(DataWidth, ByteWidth)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [NumPorts-1:0]  req_i,
  input  logic [NumPorts-1:0]  we_i,
  input  logic [AddrWidth-1:0] addr_i  [NumPorts],
  input  logic [DataWidth-1:0] wdata_i [NumPorts],
  input  logic [BeWidth-1:0]   be_i    [NumPorts],
  output logic [DataWidth-1:0] rdata_o [NumPorts]
);

  localparam sim_init_e InitMode = decode_sim_init(SimInit);

  // Elaboration-time parameter checks
  if (Latency == 0) begin : g_chk_latency
    $fatal(1, "tc_sram_generic: Latency must be >= 1");
  end
  if (NumWords == 0) begin : g_chk_num_words
    $fatal(1, "tc_sram_generic: NumWords must be >= 1");
  end
  if (DataWidth == 0) begin : g_chk_data_width
    $fatal(1, "tc_sram_generic: DataWidth must be >= 1");
  end
  if (ByteWidth == 0) begin : g_chk_byte_width
    $fatal(1, "tc_sram_generic: ByteWidth must be >= 1");
  end
  if (!sim_init_legal(SimInit)) begin : g_chk_sim_init
    $fatal(1, "tc_sram_generic: SimInit must be none, zeros, ones or random");
  end
  if (PrintSimCfg) begin : g_print_cfg
    $info("tc_sram_generic: NumWords=%0d DataWidth=%0d ByteWidth=%0d NumPorts=%0d Latency=%0d SimInit=%s",
          NumWords, DataWidth, ByteWidth, NumPorts, Latency, SimInit);
  end

  // Content loaded into a word while reset is asserted. The "random" mode
  // uses a fixed hash of the word index so the fill is repeatable.
  function automatic logic [DataWidth-1:0] init_word(input int unsigned word_idx);
    logic [DataWidth-1:0] v;
    logic [31:0]          h;
    v = '0;
    h = '0;
    case (InitMode)
      INIT_ONES: v = '1;
      INIT_RANDOM: begin
        for (int unsigned i = 0; i < DataWidth; i++) begin
          if ((i % 32) == 0) h = scramble(word_idx, i / 32);
          v[i] = h[i % 32];
        end
      end
      default: v = '0;
    endcase
    return v;
  endfunction

  function automatic logic addr_in_range(input logic [AddrWidth-1:0] a);
    return 32'(a) < NumWords;
  endfunction

  logic [DataWidth-1:0] mem_q [NumWords];

  // Per-port bit mask expanded from the lane enables; the last lane only
  // covers the bits that remain above the previous full lanes.
  logic [DataWidth-1:0] wmask [NumPorts];

  for (genvar p = 0; p < NumPorts; p++) begin : g_mask
    for (genvar l = 0; l < BeWidth; l++) begin : g_lane
      localparam int unsigned Lo = l * ByteWidth;
      localparam int unsigned Lw = (Lo + ByteWidth > DataWidth) ? (DataWidth - Lo) : ByteWidth;
      assign wmask[p][Lo +: Lw] = {Lw{be_i[p][l]}};
    end
  end

  // Storage. Ports are visited in ascending order with per-bit updates, so
  // on a same-address collision the highest port wins each enabled lane
  // while lanes only a lower port enabled still take that port's data.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      if (InitMode != INIT_NONE) begin
        for (int unsigned w = 0; w < NumWords; w++) begin
          mem_q[w] <= init_word(w);
        end
      end
    end else begin
      for (int unsigned p = 0; p < NumPorts; p++) begin
        if (req_i[p] && we_i[p] && addr_in_range(addr_i[p])) begin
          for (int unsigned i = 0; i < DataWidth; i++) begin
            if (wmask[p][i]) mem_q[addr_i[p]][i] <= wdata_i[p][i];
          end
        end
      end
    end
  end

  for (genvar p = 0; p < NumPorts; p++) begin : g_port
    logic [AddrWidth-1:0] raddr_q;
    logic [DataWidth-1:0] stage0;

    // Only a read moves the address; writes and idle cycles leave it so the
    // last read result stays on rdata_o.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        raddr_q <= '0;
      end else if (req_i[p] && !we_i[p]) begin
        raddr_q <= addr_i[p];
      end
    end

    assign stage0 = addr_in_range(raddr_q) ? mem_q[raddr_q] : 'x;

    if (Latency <= 1) begin : g_lat1
      assign rdata_o[p] = stage0;
    end else begin : g_latn
      logic [DataWidth-1:0] pipe_q [Latency-1];

      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          for (int unsigned k = 0; k < Latency - 1; k++) pipe_q[k] <= '0;
        end else begin
          pipe_q[0] <= stage0;
          for (int unsigned k = 1; k < Latency - 1; k++) pipe_q[k] <= pipe_q[k-1];
        end
      end

      assign rdata_o[p] = pipe_q[Latency-2];
    end
  end

endmodule

// File: tb/tb_tc_sram_generic.sv
module tb_tc_sram_generic;

  logic clk;
  logic rst_n;

  // Instance A: 2 ports, latency 1, 12 words (addresses 12..15 out of range), zero fill
  logic [1:0]  a_req, a_we;
  logic [3:0]  a_addr  [2];
  logic [63:0] a_wdata [2];
  logic [7:0]  a_be    [2];
  logic [63:0] a_rdata [2];

  // Instance B: 2 ports, latency 3, 8 words, ones fill
  logic [1:0]  b_req, b_we;
  logic [2:0]  b_addr  [2];
  logic [63:0] b_wdata [2];
  logic [7:0]  b_be    [2];
  logic [63:0] b_rdata [2];

  tc_sram_generic #(
    .NumWords(12), .DataWidth(64), .ByteWidth(8), .NumPorts(2),
    .Latency(1), .SimInit("zeros"), .PrintSimCfg(1'b0)
  ) dut_a (
    .clk_i(clk), .rst_ni(rst_n), .req_i(a_req), .we_i(a_we),
    .addr_i(a_addr), .wdata_i(a_wdata), .be_i(a_be), .rdata_o(a_rdata)
  );

  tc_sram_generic #(
    .NumWords(8), .DataWidth(64), .ByteWidth(8), .NumPorts(2),
    .Latency(3), .SimInit("ones"), .PrintSimCfg(1'b0)
  ) dut_b (
    .clk_i(clk), .rst_ni(rst_n), .req_i(b_req), .we_i(b_we),
    .addr_i(b_addr), .wdata_i(b_wdata), .be_i(b_be), .rdata_o(b_rdata)
  );

  // Clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int failures = 0;
  logic [63:0] exp_q[$];

  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  typedef struct {
    logic        req;
    logic        we;
    logic [3:0]  addr;
    logic [63:0] wdata;
    logic [7:0]  be;
    logic [63:0] exp;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic a_drive(input int p, input logic req, input logic we, input logic [3:0] addr,
                         input logic [63:0] wdata, input logic [7:0] be);
    a_req[p]   = req;
    a_we[p]    = we;
    a_addr[p]  = addr;
    a_wdata[p] = wdata;
    a_be[p]    = be;
  endtask

  task automatic b_drive(input int p, input logic req, input logic we, input logic [2:0] addr,
                         input logic [63:0] wdata, input logic [7:0] be);
    b_req[p]   = req;
    b_we[p]    = we;
    b_addr[p]  = addr;
    b_wdata[p] = wdata;
    b_be[p]    = be;
  endtask

  task automatic idle_all();
    for (int p = 0; p < 2; p++) begin
      a_drive(p, 1'b0, 1'b0, 4'd0, 64'h0, 8'h00);
      b_drive(p, 1'b0, 1'b0, 3'd0, 64'h0, 8'h00);
    end
  endtask

  initial begin
    logic [63:0] rmw_data;
    logic [2:0]  stream_addr[4];

    // Port-0 vectors for instance A: one cycle each, rdata_o[0] checked after the edge
    //             req   we    addr   wdata                   be     expected rdata
    vecs[0]  = '{1'b1, 1'b0, 4'd5,  64'h0,                  8'h00, 64'h0};
    vecs[1]  = '{1'b1, 1'b1, 4'd3,  64'hDEADBEEF_CAFEF00D,  8'hFF, 64'h0};
    vecs[2]  = '{1'b1, 1'b0, 4'd3,  64'h0,                  8'h00, 64'hDEADBEEF_CAFEF00D};
    vecs[3]  = '{1'b1, 1'b1, 4'd3,  64'h11223344_55667788,  8'h0F, 64'hDEADBEEF_55667788};
    vecs[4]  = '{1'b1, 1'b0, 4'd3,  64'h0,                  8'h00, 64'hDEADBEEF_55667788};
    vecs[5]  = '{1'b1, 1'b1, 4'd3,  64'hA5A5A5A5_00000000,  8'hF0, 64'hA5A5A5A5_55667788};
    vecs[6]  = '{1'b1, 1'b1, 4'd7,  64'h01234567_89ABCDEF,  8'hFF, 64'hA5A5A5A5_55667788};
    vecs[7]  = '{1'b0, 1'b1, 4'd3,  ONES,                   8'hFF, 64'hA5A5A5A5_55667788};
    vecs[8]  = '{1'b1, 1'b1, 4'd13, ONES,                   8'hFF, 64'hA5A5A5A5_55667788};
    vecs[9]  = '{1'b1, 1'b0, 4'd1,  64'h0,                  8'h00, 64'h0};
    vecs[10] = '{1'b1, 1'b1, 4'd0,  64'h99AABBCC_DDEEFF77,  8'h81, 64'h0};
    vecs[11] = '{1'b1, 1'b0, 4'd0,  64'h0,                  8'h00, 64'h99000000_00000077};
    vecs[12] = '{1'b1, 1'b0, 4'd7,  64'h0,                  8'h00, 64'h01234567_89ABCDEF};
    vecs[13] = '{1'b0, 1'b0, 4'd5,  64'h0,                  8'h00, 64'h01234567_89ABCDEF};

    // Reset
    rst_n = 1'b0;
    idle_all();
    repeat (2) @(negedge clk);
    check("reset_a_p0", a_rdata[0], 64'h0);
    check("reset_a_p1", a_rdata[1], 64'h0);
    check("reset_b_p0", b_rdata[0], 64'h0);
    check("reset_b_p1", b_rdata[1], 64'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // Table-driven single-port sequence on instance A
    for (int k = 0; k < 14; k++) begin
      a_drive(0, vecs[k].req, vecs[k].we, vecs[k].addr, vecs[k].wdata, vecs[k].be);
      @(negedge clk);
      check($sformatf("vec%0d", k), a_rdata[0], vecs[k].exp);
    end
    idle_all();

    // Read-modify-write: read, merge a 16-bit field, write back, read again
    a_drive(0, 1'b1, 1'b0, 4'd7, 64'h0, 8'h00);
    @(negedge clk);
    check("rmw_read", a_rdata[0], 64'h01234567_89ABCDEF);
    rmw_data = (a_rdata[0] & ~64'h00000000_FFFF0000) | 64'h00000000_BEEF0000;
    a_drive(0, 1'b1, 1'b1, 4'd7, rmw_data, 8'hFF);
    @(negedge clk);
    a_drive(0, 1'b1, 1'b0, 4'd7, 64'h0, 8'h00);
    @(negedge clk);
    check("rmw_merged", a_rdata[0], 64'h01234567_BEEFCDEF);

    // Dual port: same-address collisions
    a_drive(0, 1'b1, 1'b1, 4'd9,  64'hAA,   8'hFF);
    a_drive(1, 1'b1, 1'b1, 4'd9,  64'hBB,   8'hFF);
    @(negedge clk);
    a_drive(0, 1'b1, 1'b1, 4'd10, 64'h1111, 8'h03);
    a_drive(1, 1'b1, 1'b1, 4'd10, 64'h22,   8'h01);
    @(negedge clk);
    a_drive(0, 1'b1, 1'b0, 4'd9,  64'h0, 8'h00);
    a_drive(1, 1'b1, 1'b0, 4'd10, 64'h0, 8'h00);
    @(negedge clk);
    check("dp_same_addr", a_rdata[0], 64'hBB);
    check("dp_lane_prio", a_rdata[1], 64'h1122);
    a_drive(0, 1'b1, 1'b0, 4'd3, 64'h0, 8'h00);
    a_drive(1, 1'b1, 1'b0, 4'd0, 64'h0, 8'h00);
    @(negedge clk);
    check("dp_read_p0", a_rdata[0], 64'hA5A5A5A5_55667788);
    check("dp_read_p1", a_rdata[1], 64'h99000000_00000077);
    idle_all();

    // Latency 3: fill words 2, 4, 6
    b_drive(0, 1'b1, 1'b1, 3'd2, 64'h2222, 8'hFF);
    @(negedge clk);
    b_drive(0, 1'b1, 1'b1, 3'd4, 64'h4444, 8'hFF);
    @(negedge clk);
    b_drive(0, 1'b1, 1'b1, 3'd6, 64'h6666, 8'hFF);
    @(negedge clk);
    idle_all();
    repeat (3) @(negedge clk);

    // Single read: output unchanged for two cycles, data on the third
    b_drive(0, 1'b1, 1'b0, 3'd2, 64'h0, 8'h00);
    @(negedge clk);
    idle_all();
    check("lat3_n1", b_rdata[0], ONES);
    @(negedge clk);
    check("lat3_n2", b_rdata[0], ONES);
    @(negedge clk);
    check("lat3_n3", b_rdata[0], 64'h2222);

    // Back-to-back reads of 0, 2, 4, 6 stream out on consecutive cycles
    stream_addr[0] = 3'd0;
    stream_addr[1] = 3'd2;
    stream_addr[2] = 3'd4;
    stream_addr[3] = 3'd6;
    exp_q.push_back(64'h2222);
    exp_q.push_back(64'h2222);
    exp_q.push_back(ONES);
    exp_q.push_back(64'h2222);
    exp_q.push_back(64'h4444);
    exp_q.push_back(64'h6666);
    exp_q.push_back(64'h6666);
    for (int k = 0; k < 7; k++) begin
      if (k < 4) b_drive(0, 1'b1, 1'b0, stream_addr[k], 64'h0, 8'h00);
      else       b_drive(0, 1'b0, 1'b0, 3'd0, 64'h0, 8'h00);
      @(negedge clk);
      check($sformatf("stream%0d", k), b_rdata[0], exp_q.pop_front());
    end

    // Reset while a read is in flight
    b_drive(0, 1'b1, 1'b0, 3'd4, 64'h0, 8'h00);
    @(negedge clk);
    idle_all();
    #2 rst_n = 1'b0;
    #1;
    check("midrst_b_pipe", b_rdata[0], 64'h0);
    check("midrst_a_rdata", a_rdata[0], 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("postrst_b_discard", b_rdata[0], ONES);
    a_drive(0, 1'b1, 1'b0, 4'd3, 64'h0, 8'h00);
    @(negedge clk);
    idle_all();
    check("postrst_a_zeros", a_rdata[0], 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
